// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the D/E pipeline tags and the hazard controller.
// stall_cnt exists only when HAZARD_STAT_EN is defined.
interface hazard_ctrl_if;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
    logic        md_use_d;
    logic [4:0]  DEA1;
    logic [4:0]  DEA2;
    logic [4:0]  DEA3;
    logic [1:0]  DETnew;
    logic [4:0]  EMA3;
    logic [1:0]  EMTnew;
    logic [4:0]  MWA3;
    logic        start_mult;
    logic        start_div;
    logic        stall;
    logic        md_busy;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output rs_d, rt_d, tuse_rs, tuse_rt, md_use_d,
        output DEA1, DEA2, DEA3, DETnew, EMA3, EMTnew, MWA3,
        output start_mult, start_div,
        input  stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
`ifdef HAZARD_STAT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs, tuse_rt, md_use_d,
        input  DEA1, DEA2, DEA3, DETnew, EMA3, EMTnew, MWA3,
        input  start_mult, start_div,
        output stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
`ifdef HAZARD_STAT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forward decision for the 5-stage MIPS core plus the mult/div busy timer.
// Define HAZARD_STAT_EN to add the 32-bit stall_cnt statistics counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    logic [3:0] md_cnt;
    logic [3:0] md_cnt_nxt;
    logic       md_busy_q;
    logic       rs_stall;
    logic       rt_stall;
    logic       md_stall;
    logic       stall_raw;

    function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] de_a3, input logic [1:0] de_tnew,
                                        input logic [4:0] em_a3, input logic [1:0] em_tnew);
        return (src != 5'd0) && (tuse != 2'd3) &&
               (((src == de_a3) && (de_tnew > tuse)) ||
                ((src == em_a3) && (em_tnew > tuse)));
    endfunction

    // Youngest producer with a ready value wins; a not-yet-ready match falls through.
    function automatic logic [1:0] sel_d(input logic [4:0] src,
                                         input logic [4:0] de_a3, input logic [1:0] de_tnew,
                                         input logic [4:0] em_a3, input logic [1:0] em_tnew,
                                         input logic [4:0] mw_a3);
        if (src == 5'd0)
            return 2'd0;
        else if ((src == de_a3) && (de_tnew == 2'd0))
            return 2'd1;
        else if ((src == em_a3) && (em_tnew == 2'd0))
            return 2'd2;
        else if (src == mw_a3)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] src,
                                         input logic [4:0] em_a3, input logic [1:0] em_tnew,
                                         input logic [4:0] mw_a3);
        if (src == 5'd0)
            return 2'd0;
        else if ((src == em_a3) && (em_tnew == 2'd0))
            return 2'd2;
        else if (src == mw_a3)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    always_comb begin
        rs_stall  = data_stall(hz.rs_d, hz.tuse_rs, hz.DEA3, hz.DETnew, hz.EMA3, hz.EMTnew);
        rt_stall  = data_stall(hz.rt_d, hz.tuse_rt, hz.DEA3, hz.DETnew, hz.EMA3, hz.EMTnew);
        md_stall  = hz.md_use_d && (md_busy_q || hz.start_mult || hz.start_div);
        stall_raw = rs_stall || rt_stall || md_stall;
    end

    // Outputs are forced quiet while reset is held, independent of the tag inputs.
    always_comb begin
        hz.stall    = 1'b0;
        hz.fwd_rs_d = 2'd0;
        hz.fwd_rt_d = 2'd0;
        hz.fwd_rs_e = 2'd0;
        hz.fwd_rt_e = 2'd0;
        if (!reset) begin
            hz.stall    = stall_raw;
            hz.fwd_rs_d = sel_d(hz.rs_d, hz.DEA3, hz.DETnew, hz.EMA3, hz.EMTnew, hz.MWA3);
            hz.fwd_rt_d = sel_d(hz.rt_d, hz.DEA3, hz.DETnew, hz.EMA3, hz.EMTnew, hz.MWA3);
            hz.fwd_rs_e = sel_e(hz.DEA1, hz.EMA3, hz.EMTnew, hz.MWA3);
            hz.fwd_rt_e = sel_e(hz.DEA2, hz.EMA3, hz.EMTnew, hz.MWA3);
        end
    end

    always_comb begin
        md_cnt_nxt = md_cnt;
        if (hz.start_div)
            md_cnt_nxt = 4'(DIV_CYCLES);
        else if (hz.start_mult)
            md_cnt_nxt = 4'(MULT_CYCLES);
        else if (md_cnt != 4'd0)
            md_cnt_nxt = md_cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt    <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            md_cnt    <= md_cnt_nxt;
            md_busy_q <= (md_cnt_nxt != 4'd0);
        end
    end

    assign hz.md_busy = md_busy_q;

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else if (stall_raw)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule
